// File: rtl/rr_sel_arb_pkg.sv
// rr_sel_arb_pkg
// Shared types and helpers for the round-robin select arbiter.
//   arb_state_e : arbiter FSM state (IDLE = no grant, GNT = grant held)
//   wrap_inc    : index increment that wraps from n-1 to 0 by compare,
//                 so non-power-of-two requestor counts never reach n.
package rr_sel_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        GNT  = 1'b1
    } arb_state_e;

    function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
        return (idx == n - 1) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/rr_sel_arb_if.sv
// rr_sel_arb_if
// Request/grant bundle between requestors + downstream consumer and the
// arbiter.
//   i_req     : per-requestor request, held until its grant is acked
//   i_ack     : consumer accepted the currently selected beat
//   i_lock    : sampled with i_ack; keep the current winner for the next beat
//   o_gnt     : registered one-hot-or-null mux select
//   o_gnt_idx : binary index of the set bit of o_gnt (0 when idle)
//   o_gnt_vld : |o_gnt
// modport slave  : the arbiter side
// modport master : the requestor / consumer side
interface rr_sel_arb_if #(
    parameter int N = 4
);
    localparam int W = $clog2(N);

    logic [N-1:0] i_req;
    logic         i_ack;
    logic         i_lock;
    logic [N-1:0] o_gnt;
    logic [W-1:0] o_gnt_idx;
    logic         o_gnt_vld;

    modport slave (
        input  i_req,
        input  i_ack,
        input  i_lock,
        output o_gnt,
        output o_gnt_idx,
        output o_gnt_vld
    );

    modport master (
        output i_req,
        output i_ack,
        output i_lock,
        input  o_gnt,
        input  o_gnt_idx,
        input  o_gnt_vld
    );

endinterface

// File: rtl/rr_sel_arb_pick.sv
// rr_pick
// Combinational round-robin pick: first set bit of (req & ~mask) searching
// ptr, ptr+1, ... N-1, 0, ... ptr-1.
//   req      : request vector
//   mask     : bits to exclude from this pick
//   ptr      : highest-priority index (always < N)
//   pick     : one-hot winner, zero when nothing eligible
//   pick_idx : binary index of the winner, zero when nothing eligible
//   pick_vld : a winner exists
module rr_pick #(
    parameter  int N = 4,
    localparam int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [N-1:0] mask,
    input  logic [W-1:0] ptr,
    output logic [N-1:0] pick,
    output logic [W-1:0] pick_idx,
    output logic         pick_vld
);

    logic [N-1:0]   eff;
    logic [2*N-1:0] dbl;
    logic [N-1:0]   rot;
    logic [W-1:0]   off;
    logic [W:0]     sum;
    logic           found;

    // Rotating a doubled copy right by ptr puts index ptr at bit 0; since
    // ptr < N the low N bits are a clean rotation for any N.
    assign eff = req & ~mask;
    assign dbl = {eff, eff} >> ptr;
    assign rot = dbl[N-1:0];

    always_comb begin
        found = 1'b0;
        off   = '0;
        for (int i = 0; i < N; i++) begin
            if (!found && rot[i]) begin
                found = 1'b1;
                off   = W'(i);
            end
        end
        // Map the rotated offset back to an absolute index, wrapping at N.
        sum = {1'b0, off} + {1'b0, ptr};
        if (sum >= (W+1)'(N)) begin
            sum = sum - (W+1)'(N);
        end
        pick_vld = found;
        pick_idx = found ? sum[W-1:0] : '0;
    end

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_onehot
            assign pick[gi] = pick_vld && (pick_idx == W'(gi));
        end
    endgenerate

endmodule

// File: rtl/rr_sel_arb.sv
// rr_sel_arb
// Round-robin arbiter producing the registered one-hot-or-null select for a
// shared N:1 datapath mux. A grant is held until acked; a non-locked ack
// rotates priority past the winner and re-picks in the same cycle with the
// winner masked, so a lone persistent requestor sees one idle bubble between
// independent transactions. A locked ack keeps the current winner.
//   clk    : clock, rising edge
//   arst_n : asynchronous active-low reset
//   bus    : request/ack/lock in, grant select/index/valid out
module rr_sel_arb
    import rr_sel_arb_pkg::*;
#(
    parameter  int N = 4,
    localparam int W = $clog2(N)
) (
    input  logic         clk,
    input  logic         arst_n,
    rr_sel_arb_if.slave  bus
);

    arb_state_e   state_reg, state_next;
    logic [W-1:0] ptr_reg, ptr_next;
    logic [N-1:0] gnt_reg, gnt_next;
    logic [W-1:0] gnt_idx_reg, gnt_idx_next;

    logic         advance;
    logic [W-1:0] ptr_adv;
    logic [W-1:0] pick_ptr;
    logic [N-1:0] pick_mask;
    logic [N-1:0] pick;
    logic [W-1:0] pick_idx;
    logic         pick_vld;

    // A non-locked ack on a held grant retires the winner this cycle.
    assign advance   = (state_reg == GNT) && bus.i_ack && !bus.i_lock;
    assign ptr_adv   = W'(wrap_inc(int'(gnt_idx_reg), N));
    assign pick_ptr  = advance ? ptr_adv : ptr_reg;
    assign pick_mask = advance ? gnt_reg : '0;

    rr_pick #(.N(N)) u_pick (
        .req      (bus.i_req),
        .mask     (pick_mask),
        .ptr      (pick_ptr),
        .pick     (pick),
        .pick_idx (pick_idx),
        .pick_vld (pick_vld)
    );

    always_comb begin
        state_next   = state_reg;
        ptr_next     = ptr_reg;
        gnt_next     = gnt_reg;
        gnt_idx_next = gnt_idx_reg;
        case (state_reg)
            IDLE: begin
                if (pick_vld) begin
                    state_next   = GNT;
                    gnt_next     = pick;
                    gnt_idx_next = pick_idx;
                end
            end
            GNT: begin
                // Without a non-locked ack the grant is frozen, even if the
                // winner drops its request.
                if (advance) begin
                    ptr_next = ptr_adv;
                    if (pick_vld) begin
                        gnt_next     = pick;
                        gnt_idx_next = pick_idx;
                    end else begin
                        state_next   = IDLE;
                        gnt_next     = '0;
                        gnt_idx_next = '0;
                    end
                end
            end
            default: begin
                state_next   = IDLE;
                gnt_next     = '0;
                gnt_idx_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_reg   <= IDLE;
            ptr_reg     <= '0;
            gnt_reg     <= '0;
            gnt_idx_reg <= '0;
        end else begin
            state_reg   <= state_next;
            ptr_reg     <= ptr_next;
            gnt_reg     <= gnt_next;
            gnt_idx_reg <= gnt_idx_next;
        end
    end

    assign bus.o_gnt     = gnt_reg;
    assign bus.o_gnt_idx = gnt_idx_reg;
    assign bus.o_gnt_vld = |gnt_reg;

endmodule

// File: tb/tb_rr_sel_arb.sv
// tb_rr_sel_arb
// Directed bench for rr_sel_arb with an N=4 and an N=3 instance.
module tb_rr_sel_arb;

    logic clk = 1'b0;
    logic arst_n;
    always #5 clk = ~clk;

    rr_sel_arb_if #(.N(4)) if4 ();
    rr_sel_arb_if #(.N(3)) if3 ();

    rr_sel_arb #(.N(4)) dut4 (.clk(clk), .arst_n(arst_n), .bus(if4));
    rr_sel_arb #(.N(3)) dut3 (.clk(clk), .arst_n(arst_n), .bus(if3));

    int n_checks = 0;
    int n_errors = 0;
    int onehot_bad = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
        end else begin
            $display("ok   %s got=%0h", tag, obs);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Structural invariants on every cycle: one-hot-or-null select, valid
    // equals OR of select, index matches the set bit (or 0 when idle).
    always @(negedge clk) begin
        int e4;
        int e3;
        e4 = 0;
        e3 = 0;
        for (int i = 0; i < 4; i++) if (if4.o_gnt[i]) e4 = i;
        for (int i = 0; i < 3; i++) if (if3.o_gnt[i]) e3 = i;
        if (!$onehot0(if4.o_gnt) || (if4.o_gnt_vld !== (|if4.o_gnt)) ||
            (32'(if4.o_gnt_idx) != 32'(e4)))
            onehot_bad++;
        if (!$onehot0(if3.o_gnt) || (if3.o_gnt_vld !== (|if3.o_gnt)) ||
            (32'(if3.o_gnt_idx) != 32'(e3)))
            onehot_bad++;
    end

    task automatic chk4(input string tag, input logic [3:0] gnt, input int idx);
        check_val({tag, ".gnt"}, 32'(if4.o_gnt), 32'(gnt));
        check_val({tag, ".idx"}, 32'(if4.o_gnt_idx), 32'(idx));
        check_val({tag, ".vld"}, 32'(if4.o_gnt_vld), 32'(|gnt));
    endtask

    logic [3:0] seq1 [5];
    logic [3:0] tog  [10];

    initial begin
        seq1 = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        tog  = '{4'b1111, 4'b0000, 4'b1001, 4'b0110, 4'b0010,
                 4'b1101, 4'b0000, 4'b0111, 4'b1000, 4'b1111};
        arst_n = 1'b0;
        if4.i_req = '0; if4.i_ack = 1'b0; if4.i_lock = 1'b0;
        if3.i_req = '0; if3.i_ack = 1'b0; if3.i_lock = 1'b0;

        // Reset state
        step(); step();
        chk4("rst", 4'b0000, 0);
        check_val("rst3.gnt", 32'(if3.o_gnt), 32'd0);
        arst_n = 1'b1;

        // All requesting, continuous ack: no bubbles, strict rotation.
        if4.i_req = 4'b1111; if4.i_ack = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            check_val($sformatf("rr4.%0d", k), 32'(if4.o_gnt), 32'(seq1[k]));
        end
        if4.i_req = 4'b0000;
        step();
        chk4("rr4.drain", 4'b0000, 0);          // ptr now 1
        if4.i_ack = 1'b0;

        // Lone persistent requestor: one idle bubble before re-grant.
        if4.i_req = 4'b0100;
        step(); chk4("lone.g1", 4'b0100, 2);
        if4.i_ack = 1'b1;
        step(); chk4("lone.bub", 4'b0000, 0);   // ptr now 3
        step(); chk4("lone.g2", 4'b0100, 2);
        if4.i_req = 4'b0000;
        step(); chk4("lone.end", 4'b0000, 0);   // ptr stays 3
        if4.i_ack = 1'b0;

        // Locked burst on index 1, then unlock with 1011 pending.
        if4.i_req = 4'b0010;
        step(); chk4("lock.b0", 4'b0010, 1);
        if4.i_req = 4'b1011; if4.i_ack = 1'b1; if4.i_lock = 1'b1;
        for (int k = 1; k < 4; k++) begin
            step(); chk4($sformatf("lock.b%0d", k), 4'b0010, 1);
        end
        if4.i_lock = 1'b0;
        step(); chk4("lock.next", 4'b1000, 3); // ptr 2, bit 2 absent -> 3
        if4.i_req = 4'b0000;
        step(); chk4("lock.end", 4'b0000, 0);   // ptr now 0
        if4.i_ack = 1'b0;

        // N=3: all requesting, continuous ack.
        if3.i_req = 3'b111; if3.i_ack = 1'b1;
        for (int k = 0; k < 6; k++) begin
            step();
            check_val($sformatf("n3.idx%0d", k), 32'(if3.o_gnt_idx), 32'(k % 3));
            check_val($sformatf("n3.gnt%0d", k), 32'(if3.o_gnt), 32'(1 << (k % 3)));
        end
        if3.i_req = 3'b000;
        step();
        check_val("n3.end", 32'(if3.o_gnt), 32'd0);
        if3.i_ack = 1'b0;

        // Held grant with no ack while requests churn.
        if4.i_req = 4'b0010;
        step(); chk4("hold.g", 4'b0010, 1);
        for (int k = 0; k < 10; k++) begin
            if4.i_req = tog[k];
            step();
            check_val($sformatf("hold.%0d", k), 32'(if4.o_gnt), 32'h2);
        end
        if4.i_req = 4'b0000; if4.i_ack = 1'b1;
        step(); chk4("hold.end", 4'b0000, 0);   // ptr now 2
        if4.i_ack = 1'b0;

        // Asynchronous reset in the middle of a locked transfer.
        if4.i_req = 4'b1111;
        step(); chk4("ar.g", 4'b0100, 2);
        if4.i_ack = 1'b1; if4.i_lock = 1'b1;
        step(); chk4("ar.lk", 4'b0100, 2);
        arst_n = 1'b0;
        #1;
        chk4("ar.async", 4'b0000, 0);
        if4.i_ack = 1'b0; if4.i_lock = 1'b0;
        step(); chk4("ar.held", 4'b0000, 0);
        arst_n = 1'b1;
        step(); chk4("ar.first", 4'b0001, 0);

        #2;
        check_val("onehot0", 32'(onehot_bad), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
